zorgian_transaction_sequencer: RTL and testbench
================================================

ZORGIAN_TRANSACTION_SEQUENCER -- requirements
Module: zorgian_transaction_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, cycles a button must be stable before it is accepted (10 ms at 100 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, flip-flop stages in each button synchronizer.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; all state is clocked on the rising edge of CLOCK_100.
REQ-004 CLOCK_100  in  1  system clock, 100 MHz.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 buy_btn  in  1  raw asynchronous purchase button.
REQ-007 load_btn  in  1  raw asynchronous inventory-load button.
REQ-008 cost_in, paid_in  in  4 each  switch values sampled at purchase.
REQ-009 load_pentagons, load_triangles, load_circles  in  2 each  inventory counts loaded on load press.
REQ-010 Cost, Paid  out  4 each  latched transaction values driven to the change box.
REQ-011 Pentagons, Triangles, Circles  out  2 each  current inventory counts driven to the change box.
REQ-012 FirstCoin, SecondCoin  in  3 each  change-box coin decisions.
REQ-013 ExactAmount, NotEnoughChange, CoughUpMore  in  1 each  change-box status.
REQ-014 busy  out  1  high from LATCH through DECIDE.
REQ-015 done  out  1  one-cycle pulse in the cycle after DECIDE.
REQ-016 last_status  out  2  result of the most recent transaction.
REQ-017 underflow  out  1  sticky; set when a decrement would go below zero.
REQ-018 txn_count  out  8  count of committed (non-rejected) transactions, wraps 255->0.

Function
REQ-019 Each button SHALL pass through the synchronizer, then the debounce counter; only a rising edge of the debounced level SHALL produce a one-cycle press pulse.
REQ-020 The FSM SHALL have states IDLE, LATCH, SETTLE, DECIDE.
REQ-021 On a buy press in IDLE, the FSM SHALL go to LATCH and capture cost_in and paid_in into Cost and Paid.
REQ-022 LATCH SHALL go to SETTLE unconditionally; SETTLE SHALL go to DECIDE unconditionally (one cycle for the combinational change box to settle).
REQ-023 DECIDE SHALL sample the change-box inputs and return to IDLE; inventory and status updates SHALL be visible in the following cycle, together with the done pulse.
REQ-024 Latency from buy press pulse to done SHALL be exactly 4 cycles.
REQ-025 Decision priority:
- CoughUpMore or NotEnoughChange gives REJECT (status 3); inventory and txn_count are unchanged.
- Otherwise ExactAmount gives EXACT (status 1), with txn_count+1 and no decrement.
- Otherwise CHANGE (status 2), with txn_count+1 and a decrement for each coin.
REQ-026 Coin encodings: 3'b001 circle, 3'b011 triangle, 3'b101 pentagon, anything else none.
- When FirstCoin and SecondCoin are the same type, that count SHALL drop by 2.
REQ-027 Decrements SHALL saturate at 0; any saturation SHALL set underflow, which is cleared only by reset or a load.
REQ-028 A load press in IDLE SHALL copy the load_* values into the inventory, clear underflow and set last_status to NONE (0) in the next cycle.
REQ-029 Presses outside IDLE SHALL be ignored (not queued).
REQ-030 Simultaneous buy and load presses in IDLE: load wins and the buy is discarded.
REQ-031 Cost and Paid SHALL hold their latched values until the next LATCH.

Reset
REQ-032 On reset_n low, the block SHALL asynchronously enter IDLE and clear the debounce and synchronizer state.
- All outputs SHALL be 0: Cost, Paid, inventory counts, busy, done, last_status, underflow, txn_count.
REQ-033 A reset in mid-transaction SHALL abort it with no inventory change and no done pulse.

Structure
REQ-034 Package zorgian_pkg SHALL hold:
- coin_t enum (COIN_NONE, COIN_CIRCLE, COIN_TRIANGLE, COIN_PENTAGON with the encodings above);
- seq_state_t enum;
- status_t enum (NONE=0, EXACT=1, CHANGE=2, REJECT=3).
REQ-035 Synchronize, debounce and edge-detect SHALL be one sub-module, button_conditioner, instantiated once per button.

Verification (DEBOUNCE_CYCLES=4 for simulation)
REQ-036 Load 3/3/3, then buy with Cost=7, Paid=12 and the box returning pentagon+none -> done exactly 4 cycles after the press pulse; Pentagons=2; status=2; txn_count=1.
REQ-037 Inventory Circles=1, box returns circle+circle -> Circles=0, underflow=1; a following load clears underflow.
REQ-038 CoughUpMore=1 (Cost=9, Paid=4) -> status=3; inventory and txn_count unchanged.
REQ-039 Buy held with 3-cycle glitches before it is stable -> exactly one transaction; a second buy press while busy is ignored.
REQ-040 Buy and load pressed in the same cycle -> inventory equals the load_* values; no transaction and no done pulse.
REQ-041 reset_n asserted in SETTLE -> all outputs 0 immediately; no done pulse; txn_count=0.

Source files
------------

// File: rtl/zorgian_pkg.sv
// Shared types for the transaction sequencer: coin encodings, FSM states,
// transaction result codes and inventory slot indices.
package zorgian_pkg;

  typedef enum logic [2:0] {
    COIN_NONE     = 3'b000,
    COIN_CIRCLE   = 3'b001,
    COIN_TRIANGLE = 3'b011,
    COIN_PENTAGON = 3'b101
  } coin_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LATCH  = 2'd1,
    SETTLE = 2'd2,
    DECIDE = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    EXACT  = 2'd1,
    CHANGE = 2'd2,
    REJECT = 2'd3
  } status_t;

  localparam int INV_PENT  = 0;
  localparam int INV_TRI   = 1;
  localparam int INV_CIRC  = 2;
  localparam int INV_SLOTS = 3;

  function automatic coin_t inv_kind(input int idx);
    case (idx)
      INV_PENT: return COIN_PENTAGON;
      INV_TRI:  return COIN_TRIANGLE;
      INV_CIRC: return COIN_CIRCLE;
      default:  return COIN_NONE;
    endcase
  endfunction

  // Number of the two dispensed coins (0..2) that are of the given kind.
  function automatic logic [1:0] coin_hits(input logic [2:0] first, input logic [2:0] second,
                                           input coin_t kind);
    return {1'b0, first == kind} + {1'b0, second == kind};
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Synchronizer, debounce counter and rising-edge detector for one raw button;
// press_o pulses for one cycle when the debounced level goes high.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   press_q, press_d;
  logic                   synced;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign press_o = press_q;

  // The level must disagree with the accepted level for DEBOUNCE_CYCLES
  // consecutive cycles before it is taken; any bounce restarts the count.
  always_comb begin
    sync_d   = SYNC_STAGES'({sync_q, btn_i});
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (synced != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = synced;
        press_d  = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

endmodule

// File: rtl/zorgian_transaction_sequencer.sv
// Purchase/load sequencer: latches a transaction, waits for the change box to
// settle, then applies its decision to the coin inventory and status outputs.
module zorgian_transaction_sequencer
  import zorgian_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       CLOCK_100,
  input  logic       reset_n,
  input  logic       buy_btn,
  input  logic       load_btn,
  input  logic [3:0] cost_in,
  input  logic [3:0] paid_in,
  input  logic [1:0] load_pentagons,
  input  logic [1:0] load_triangles,
  input  logic [1:0] load_circles,
  output logic [3:0] Cost,
  output logic [3:0] Paid,
  output logic [1:0] Pentagons,
  output logic [1:0] Triangles,
  output logic [1:0] Circles,
  input  logic [2:0] FirstCoin,
  input  logic [2:0] SecondCoin,
  input  logic       ExactAmount,
  input  logic       NotEnoughChange,
  input  logic       CoughUpMore,
  output logic       busy,
  output logic       done,
  output logic [1:0] last_status,
  output logic       underflow,
  output logic [7:0] txn_count
);

  localparam int BTN_BUY  = 0;
  localparam int BTN_LOAD = 1;

  logic [1:0] btn_raw;
  logic [1:0] btn_press;

  assign btn_raw = {load_btn, buy_btn};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_cond (
      .clk    (CLOCK_100),
      .rst_n  (reset_n),
      .btn_i  (btn_raw[gi]),
      .press_o(btn_press[gi])
    );
  end

  seq_state_t                  state_q, state_d;
  logic [3:0]                  cost_q, cost_d;
  logic [3:0]                  paid_q, paid_d;
  logic [INV_SLOTS-1:0][1:0]   inv_q, inv_d;
  logic                        done_q, done_d;
  status_t                     status_q, status_d;
  logic                        uf_q, uf_d;
  logic [7:0]                  txn_q, txn_d;

  logic [INV_SLOTS-1:0][1:0]   hit;
  logic [INV_SLOTS-1:0][1:0]   inv_dec;
  logic [INV_SLOTS-1:0]        lack;

  // Per-slot saturating decrement; a pair of the same coin takes two.
  for (genvar gi = 0; gi < INV_SLOTS; gi++) begin : g_inv
    assign hit[gi]     = coin_hits(FirstCoin, SecondCoin, inv_kind(gi));
    assign lack[gi]    = hit[gi] > inv_q[gi];
    assign inv_dec[gi] = lack[gi] ? 2'd0 : inv_q[gi] - hit[gi];
  end

  always_comb begin
    state_d  = state_q;
    cost_d   = cost_q;
    paid_d   = paid_q;
    inv_d    = inv_q;
    done_d   = 1'b0;
    status_d = status_q;
    uf_d     = uf_q;
    txn_d    = txn_q;
    case (state_q)
      IDLE: begin
        if (btn_press[BTN_LOAD]) begin
          inv_d    = {load_circles, load_triangles, load_pentagons};
          uf_d     = 1'b0;
          status_d = NONE;
        end else if (btn_press[BTN_BUY]) begin
          state_d = LATCH;
          cost_d  = cost_in;
          paid_d  = paid_in;
        end
      end
      LATCH:  state_d = SETTLE;
      SETTLE: state_d = DECIDE;
      DECIDE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (CoughUpMore || NotEnoughChange) begin
          status_d = REJECT;
        end else if (ExactAmount) begin
          status_d = EXACT;
          txn_d    = txn_q + 8'd1;
        end else begin
          status_d = CHANGE;
          txn_d    = txn_q + 8'd1;
          inv_d    = inv_dec;
          uf_d     = uf_q | (|lack);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cost_q   <= '0;
      paid_q   <= '0;
      inv_q    <= '0;
      done_q   <= 1'b0;
      status_q <= NONE;
      uf_q     <= 1'b0;
      txn_q    <= '0;
    end else begin
      state_q  <= state_d;
      cost_q   <= cost_d;
      paid_q   <= paid_d;
      inv_q    <= inv_d;
      done_q   <= done_d;
      status_q <= status_d;
      uf_q     <= uf_d;
      txn_q    <= txn_d;
    end
  end

  assign Cost        = cost_q;
  assign Paid        = paid_q;
  assign Pentagons   = inv_q[INV_PENT];
  assign Triangles   = inv_q[INV_TRI];
  assign Circles     = inv_q[INV_CIRC];
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign last_status = status_q;
  assign underflow   = uf_q;
  assign txn_count   = txn_q;

endmodule

// File: tb/tb_zorgian_transaction_sequencer.sv
// Bench for the transaction sequencer: directed vector table, hand-written
// corner sequences and randomized transactions against an inventory model.
module tb_zorgian_transaction_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       buy_btn = 1'b0, load_btn = 1'b0;
  logic [3:0] cost_in = '0, paid_in = '0;
  logic [1:0] load_pentagons = '0, load_triangles = '0, load_circles = '0;
  logic [3:0] Cost, Paid;
  logic [1:0] Pentagons, Triangles, Circles;
  logic [2:0] FirstCoin = '0, SecondCoin = '0;
  logic       ExactAmount = 1'b0, NotEnoughChange = 1'b0, CoughUpMore = 1'b0;
  logic       busy, done, underflow;
  logic [1:0] last_status;
  logic [7:0] txn_count;

  zorgian_transaction_sequencer #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .CLOCK_100(clk), .reset_n(reset_n), .buy_btn(buy_btn), .load_btn(load_btn),
    .cost_in(cost_in), .paid_in(paid_in), .load_pentagons(load_pentagons),
    .load_triangles(load_triangles), .load_circles(load_circles),
    .Cost(Cost), .Paid(Paid), .Pentagons(Pentagons), .Triangles(Triangles),
    .Circles(Circles), .FirstCoin(FirstCoin), .SecondCoin(SecondCoin),
    .ExactAmount(ExactAmount), .NotEnoughChange(NotEnoughChange),
    .CoughUpMore(CoughUpMore), .busy(busy), .done(done), .last_status(last_status),
    .underflow(underflow), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: inventory indexed 0=pentagon, 1=triangle, 2=circle.
  int m_inv[3];
  int m_txn;
  int m_st;
  bit m_uf;

  typedef struct {
    bit       do_load;
    bit [1:0] lp, lt, lc;
    bit [3:0] cost, paid;
    bit [2:0] fc, sc;
    bit       ex, nec, cum;
    bit [1:0] ep, et, ec, est;
    bit [7:0] etxn;
    bit       euf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int coin_idx(input logic [2:0] c);
    case (c)
      3'b101:  return 0;
      3'b011:  return 1;
      3'b001:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    foreach (m_inv[k]) m_inv[k] = 0;
    m_txn = 0;
    m_st  = 0;
    m_uf  = 1'b0;
  endtask

  task automatic model_load();
    m_inv[0] = int'(load_pentagons);
    m_inv[1] = int'(load_triangles);
    m_inv[2] = int'(load_circles);
    m_uf = 1'b0;
    m_st = 0;
  endtask

  // Coins are paid out one at a time; an empty slot flags underflow.
  task automatic model_buy();
    logic [2:0] coins[2];
    int idx;
    coins[0] = FirstCoin;
    coins[1] = SecondCoin;
    if (CoughUpMore || NotEnoughChange) begin
      m_st = 3;
    end else if (ExactAmount) begin
      m_st  = 1;
      m_txn = (m_txn + 1) % 256;
    end else begin
      m_st  = 2;
      m_txn = (m_txn + 1) % 256;
      for (int k = 0; k < 2; k++) begin
        idx = coin_idx(coins[k]);
        if (idx >= 0) begin
          if (m_inv[idx] == 0) m_uf = 1'b1;
          else m_inv[idx] = m_inv[idx] - 1;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pent"}, 32'(Pentagons), m_inv[0]);
    check({tag, "_tri"}, 32'(Triangles), m_inv[1]);
    check({tag, "_circ"}, 32'(Circles), m_inv[2]);
    check({tag, "_status"}, 32'(last_status), m_st);
    check({tag, "_txn"}, 32'(txn_count), m_txn);
    check({tag, "_uf"}, 32'(underflow), 32'(m_uf));
  endtask

  task automatic release_btns();
    buy_btn  = 1'b0;
    load_btn = 1'b0;
    repeat (8) tick();
  endtask

  // Button raised at tick 0: 2 sync stages + 4 stable cycles -> press at 6,
  // LATCH at 7, done at 10 (four cycles after the press pulse).
  task automatic run_buy(input string tag);
    int t_busy, t_done, n_done;
    logic [3:0] c0, p0;
    t_busy = -1; t_done = -1; n_done = 0;
    c0 = cost_in;
    p0 = paid_in;
    buy_btn = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (busy && t_busy < 0) t_busy = i;
      if (done) begin
        n_done++;
        if (t_done < 0) t_done = i;
      end
      if (i == 7) begin
        check({tag, "_cost_latch"}, 32'(Cost), 32'(c0));
        check({tag, "_paid_latch"}, 32'(Paid), 32'(p0));
      end
      if (i == 8) begin
        cost_in = ~cost_in;
        paid_in = ~paid_in;
      end
    end
    check({tag, "_busy_start"}, t_busy, 7);
    check({tag, "_done_cycle"}, t_done, 10);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_cost_hold"}, 32'(Cost), 32'(c0));
    model_buy();
    release_btns();
    check_model(tag);
  endtask

  task automatic run_load(input string tag);
    load_btn = 1'b1;
    repeat (7) tick();
    check({tag, "_load_busy"}, 32'(busy), 0);
    model_load();
    check_model(tag);
    release_btns();
  endtask

  task automatic set_box(input logic [2:0] fc, input logic [2:0] sc,
                         input logic ex, input logic nec, input logic cum);
    FirstCoin = fc; SecondCoin = sc;
    ExactAmount = ex; NotEnoughChange = nec; CoughUpMore = cum;
  endtask

  initial begin
    int n_done;
    int busy_seen;
    int glitch[8];
    logic [2:0] pick[8];

    vecs[0] = '{1'b1, 2'd3, 2'd3, 2'd3, 4'd7, 4'd12, 3'b101, 3'b000, 1'b0, 1'b0, 1'b0,
                2'd2, 2'd3, 2'd3, 2'd2, 8'd1, 1'b0};
    vecs[1] = '{1'b1, 2'd0, 2'd2, 2'd1, 4'd3, 4'd5, 3'b001, 3'b001, 1'b0, 1'b0, 1'b0,
                2'd0, 2'd2, 2'd0, 2'd2, 8'd2, 1'b1};
    vecs[2] = '{1'b1, 2'd1, 2'd1, 2'd1, 4'd9, 4'd4, 3'b011, 3'b000, 1'b0, 1'b0, 1'b1,
                2'd1, 2'd1, 2'd1, 2'd3, 8'd2, 1'b0};
    vecs[3] = '{1'b0, 2'd0, 2'd0, 2'd0, 4'd5, 4'd5, 3'b011, 3'b001, 1'b1, 1'b0, 1'b0,
                2'd1, 2'd1, 2'd1, 2'd1, 8'd3, 1'b0};
    vecs[4] = '{1'b0, 2'd0, 2'd0, 2'd0, 4'd2, 4'd8, 3'b011, 3'b011, 1'b0, 1'b0, 1'b0,
                2'd1, 2'd0, 2'd1, 2'd2, 8'd4, 1'b1};
    vecs[5] = '{1'b0, 2'd0, 2'd0, 2'd0, 4'd6, 4'd9, 3'b101, 3'b000, 1'b1, 1'b1, 1'b0,
                2'd1, 2'd0, 2'd1, 2'd3, 8'd4, 1'b1};
    vecs[6] = '{1'b0, 2'd0, 2'd0, 2'd0, 4'd1, 4'd3, 3'b111, 3'b010, 1'b0, 1'b0, 1'b0,
                2'd1, 2'd0, 2'd1, 2'd2, 8'd5, 1'b1};
    vecs[7] = '{1'b0, 2'd0, 2'd0, 2'd0, 4'd4, 4'd10, 3'b101, 3'b001, 1'b0, 1'b0, 1'b0,
                2'd0, 2'd0, 2'd0, 2'd2, 8'd6, 1'b1};
    glitch = '{1, 1, 1, 0, 1, 1, 1, 0};
    pick   = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b001, 3'b011, 3'b101, 3'b110};

    // Reset state
    repeat (3) tick();
    check("rst_cost", 32'(Cost), 0);
    check("rst_paid", 32'(Paid), 0);
    check("rst_pent", 32'(Pentagons), 0);
    check("rst_tri", 32'(Triangles), 0);
    check("rst_circ", 32'(Circles), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_status", 32'(last_status), 0);
    check("rst_uf", 32'(underflow), 0);
    check("rst_txn", 32'(txn_count), 0);
    reset_n = 1'b1;
    repeat (2) tick();
    model_reset();

    // Directed vector table
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].do_load) begin
        load_pentagons = vecs[v].lp;
        load_triangles = vecs[v].lt;
        load_circles   = vecs[v].lc;
        run_load($sformatf("vec%0d_ld", v));
      end
      cost_in = vecs[v].cost;
      paid_in = vecs[v].paid;
      set_box(vecs[v].fc, vecs[v].sc, vecs[v].ex, vecs[v].nec, vecs[v].cum);
      run_buy($sformatf("vec%0d_m", v));
      check($sformatf("vec%0d_pent", v), 32'(Pentagons), 32'(vecs[v].ep));
      check($sformatf("vec%0d_tri", v), 32'(Triangles), 32'(vecs[v].et));
      check($sformatf("vec%0d_circ", v), 32'(Circles), 32'(vecs[v].ec));
      check($sformatf("vec%0d_status", v), 32'(last_status), 32'(vecs[v].est));
      check($sformatf("vec%0d_txn", v), 32'(txn_count), 32'(vecs[v].etxn));
      check($sformatf("vec%0d_uf", v), 32'(underflow), 32'(vecs[v].euf));
    end

    // Bouncy buy: two 3-cycle glitches, then held -> one transaction only
    load_pentagons = 2'd2; load_triangles = 2'd2; load_circles = 2'd2;
    run_load("glitch_ld");
    set_box(3'b101, 3'b000, 1'b0, 1'b0, 1'b0);
    n_done = 0;
    for (int j = 0; j < 8; j++) begin
      buy_btn = glitch[j][0];
      tick();
      if (done) n_done++;
    end
    buy_btn = 1'b1;
    for (int j = 0; j < 24; j++) begin
      tick();
      if (done) n_done++;
    end
    check("glitch_done_count", n_done, 1);
    model_buy();
    release_btns();
    check_model("glitch");

    // Load press landing in SETTLE is ignored
    load_pentagons = 2'd3; load_triangles = 2'd1; load_circles = 2'd0;
    set_box(3'b011, 3'b000, 1'b0, 1'b0, 1'b0);
    n_done = 0;
    buy_btn = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 2) load_btn = 1'b1;
      if (done) n_done++;
    end
    check("busyload_done_count", n_done, 1);
    model_buy();
    release_btns();
    check_model("busyload");

    // Simultaneous buy and load: load wins, no transaction
    load_pentagons = 2'd1; load_triangles = 2'd3; load_circles = 2'd2;
    n_done = 0; busy_seen = 0;
    buy_btn = 1'b1;
    load_btn = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (done) n_done++;
      if (busy) busy_seen++;
    end
    check("simul_done_count", n_done, 0);
    check("simul_busy", busy_seen, 0);
    model_load();
    release_btns();
    check_model("simul");

    // Randomized transactions against the model
    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(0, 2) == 0) begin
        load_pentagons = 2'($urandom_range(0, 3));
        load_triangles = 2'($urandom_range(0, 3));
        load_circles   = 2'($urandom_range(0, 3));
        run_load($sformatf("rnd%0d_ld", r));
      end
      cost_in = 4'($urandom_range(0, 15));
      paid_in = 4'($urandom_range(0, 15));
      set_box(pick[$urandom_range(0, 7)], pick[$urandom_range(0, 7)],
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 5) == 0));
      run_buy($sformatf("rnd%0d", r));
    end

    // Reset asserted in SETTLE aborts the transaction
    load_pentagons = 2'd3; load_triangles = 2'd3; load_circles = 2'd3;
    run_load("abort_ld");
    cost_in = 4'd11; paid_in = 4'd13;
    set_box(3'b001, 3'b101, 1'b0, 1'b0, 1'b0);
    buy_btn = 1'b1;
    repeat (8) tick();
    check("abort_busy_before", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("abort_cost", 32'(Cost), 0);
    check("abort_paid", 32'(Paid), 0);
    check("abort_pent", 32'(Pentagons), 0);
    check("abort_tri", 32'(Triangles), 0);
    check("abort_circ", 32'(Circles), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_status", 32'(last_status), 0);
    check("abort_uf", 32'(underflow), 0);
    check("abort_txn", 32'(txn_count), 0);
    buy_btn = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (done) n_done++;
    end
    check("abort_done_count", n_done, 0);
    model_reset();
    check_model("abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
